// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

    // All-zero word decodes as an illegal instruction, so a timed-out fetch traps.
    localparam logic [31:0] ILLEGAL_INSTRUCTION = 32'h0000_0000;

    // Master indices as stored in last_grant.
    localparam logic M0_IDX = 1'b0;
    localparam logic M1_IDX = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

endpackage : mem_bus_arbiter_pkg

// File: rtl/mem_bus_arbiter_bus_timeout_ctr.sv
// Grant-duration counter: flags the last cycle a grant may run without s_ready.
module bus_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Count grant cycles; clear has priority so the count never reaches a wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Expiry is only meaningful while a grant is running.
    always_comb begin
        expired = enable && (count == LAST);
    end

endmodule : bus_timeout_ctr

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of the CPU memory decoder.
// One picorv32-style transaction at a time; grant held until s_ready or timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = ILLEGAL_INSTRUCTION
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    arb_state_e state, state_next;
    logic       last_grant, last_grant_next;
    logic       in_grant, cur_valid, abort, done_ok, done_to;
    logic       ctr_clear, expired;
    logic [31:0] done_rdata;

    bus_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (ctr_clear),
        .enable (in_grant),
        .expired(expired)
    );

    // State and round-robin history registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= M1_IDX;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // Completion decode for the owning master; a dropped valid aborts silently.
    always_comb begin
        in_grant   = (state != IDLE);
        cur_valid  = (state == GRANT1) ? m1_valid : m0_valid;
        abort      = in_grant && !cur_valid;
        done_ok    = in_grant && cur_valid && s_ready;
        done_to    = in_grant && cur_valid && !s_ready && expired;
        ctr_clear  = !in_grant || done_ok || done_to || abort;
        done_rdata = done_ok ? s_rdata : (done_to ? ERR_RDATA : '0);
    end

    // Next-state and arbitration: ties go to the master not granted last.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_next = (last_grant == M0_IDX) ? GRANT1 : GRANT0;
                end else if (m0_valid) begin
                    state_next = GRANT0;
                end else if (m1_valid) begin
                    state_next = GRANT1;
                end
            end
            GRANT0: begin
                if (done_ok || done_to) begin
                    state_next      = IDLE;
                    last_grant_next = M0_IDX;
                end else if (abort) begin
                    state_next = IDLE;
                end
            end
            GRANT1: begin
                if (done_ok || done_to) begin
                    state_next      = IDLE;
                    last_grant_next = M1_IDX;
                end else if (abort) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Downstream mux and master responses, all zero outside a grant.
    always_comb begin
        s_valid     = 1'b0;
        s_instr     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        grant       = 2'b00;
        m0_ready    = 1'b0;
        m0_rdata    = '0;
        m1_ready    = 1'b0;
        m1_rdata    = '0;
        timeout_err = 1'b0;
        case (state)
            GRANT0: begin
                s_valid     = 1'b1;
                s_instr     = m0_instr;
                s_addr      = m0_addr;
                s_wdata     = m0_wdata;
                s_wstrb     = m0_wstrb;
                grant       = 2'b01;
                m0_ready    = done_ok || done_to;
                m0_rdata    = done_rdata;
                timeout_err = done_to;
            end
            GRANT1: begin
                s_valid     = 1'b1;
                s_addr      = m1_addr;
                s_wdata     = m1_wdata;
                s_wstrb     = m1_wstrb;
                grant       = 2'b10;
                m1_ready    = done_ok || done_to;
                m1_rdata    = done_rdata;
                timeout_err = done_to;
            end
            default: ;
        endcase
    end

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with an 8-cycle timeout.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_valid, m0_instr;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_ready;
    logic [31:0] m0_rdata;
    logic        m1_valid;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_ready;
    logic [31:0] m1_rdata;
    logic        s_valid, s_instr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(8),
        .ERR_RDATA     (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m0_valid   (m0_valid),
        .m0_instr   (m0_instr),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_wstrb   (m0_wstrb),
        .m0_ready   (m0_ready),
        .m0_rdata   (m0_rdata),
        .m1_valid   (m1_valid),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_wstrb   (m1_wstrb),
        .m1_ready   (m1_ready),
        .m1_rdata   (m1_rdata),
        .s_valid    (s_valid),
        .s_instr    (s_instr),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_ready    (s_ready),
        .s_rdata    (s_rdata),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks follow #1 later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] exp_grant [8];
        exp_grant = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

        reset_n  = 1'b0;
        m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready  = 1'b0; s_rdata = '0;
        next_cycle(); next_cycle();
        #1;
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_m0_ready", 32'(m0_ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_ready), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);

        // m0 read, downstream answers on the third cycle after the request.
        reset_n  = 1'b1;
        m0_valid = 1'b1; m0_addr = 32'h4000_0010; m0_wstrb = 4'h0;
        #1;
        chk("t1_idle_s_valid", 32'(s_valid), 32'd0);
        next_cycle(); #1;
        chk("t1_s_valid", 32'(s_valid), 32'd1);
        chk("t1_grant", 32'(grant), 32'd1);
        chk("t1_s_addr", s_addr, 32'h4000_0010);
        chk("t1_m0_ready_early", 32'(m0_ready), 32'd0);
        next_cycle(); #1;
        chk("t1_m0_ready_wait", 32'(m0_ready), 32'd0);
        next_cycle();
        s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_m0_ready", 32'(m0_ready), 32'd1);
        chk("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t1_m1_ready", 32'(m1_ready), 32'd0);
        chk("t1_terr", 32'(timeout_err), 32'd0);
        next_cycle();
        s_ready = 1'b0; m0_valid = 1'b0;
        #1;
        chk("t1_back_idle", 32'(grant), 32'd0);
        chk("t1_idle_ready", 32'(m0_ready), 32'd0);

        // Fairness from reset: both masters request continuously.
        reset_n = 1'b0;
        next_cycle();
        reset_n  = 1'b1;
        m0_valid = 1'b1; m0_addr = 32'h0000_1000; m0_instr = 1'b1;
        m1_valid = 1'b1; m1_addr = 32'h2000_0000;
        s_ready  = 1'b1; s_rdata = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            next_cycle(); #1;
            chk($sformatf("rr_grant_%0d", i), 32'(grant), 32'(exp_grant[i]));
            chk($sformatf("rr_m0_ready_%0d", i), 32'(m0_ready), 32'(exp_grant[i] == 2'b01));
            chk($sformatf("rr_m1_ready_%0d", i), 32'(m1_ready), 32'(exp_grant[i] == 2'b10));
            if (exp_grant[i] == 2'b10) begin
                chk($sformatf("rr_s_addr_%0d", i), s_addr, 32'h2000_0000);
                chk($sformatf("rr_s_instr_%0d", i), 32'(s_instr), 32'd0);
                chk($sformatf("rr_m1_rdata_%0d", i), m1_rdata, 32'h1234_5678);
            end
        end
        m0_valid = 1'b0; m1_valid = 1'b0; m0_instr = 1'b0; s_ready = 1'b0;

        // m1 write never answered: forced completion on the eighth grant cycle.
        reset_n = 1'b0;
        next_cycle();
        reset_n  = 1'b1;
        m1_valid = 1'b1; m1_addr = 32'hC100_0000; m1_wdata = 32'hA5A5_5A5A; m1_wstrb = 4'hF;
        s_rdata  = 32'h7777_7777;
        for (int i = 0; i < 8; i++) begin
            next_cycle(); #1;
            chk($sformatf("to1_grant_%0d", i), 32'(grant), 32'd2);
            chk($sformatf("to1_m1_ready_%0d", i), 32'(m1_ready), 32'(i == 7));
            chk($sformatf("to1_terr_%0d", i), 32'(timeout_err), 32'(i == 7));
        end
        chk("to1_m1_rdata", m1_rdata, 32'h0000_0000);
        chk("to1_s_wstrb", 32'(s_wstrb), 32'hF);
        chk("to1_s_wdata", s_wdata, 32'hA5A5_5A5A);
        next_cycle();
        m1_valid = 1'b0;
        #1;
        chk("to1_idle_grant", 32'(grant), 32'd0);
        chk("to1_idle_terr", 32'(timeout_err), 32'd0);

        // m0 instruction fetch timing out.
        m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h0000_0200;
        for (int i = 0; i < 8; i++) begin
            next_cycle(); #1;
            chk($sformatf("to0_s_instr_%0d", i), 32'(s_instr), 32'd1);
            chk($sformatf("to0_m0_ready_%0d", i), 32'(m0_ready), 32'(i == 7));
        end
        chk("to0_m0_rdata", m0_rdata, 32'h0000_0000);
        chk("to0_terr", 32'(timeout_err), 32'd1);
        next_cycle();
        m0_valid = 1'b0; m0_instr = 1'b0;
        #1;
        chk("to0_idle_grant", 32'(grant), 32'd0);

        // s_ready on the exact timeout cycle: normal completion wins.
        m1_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            next_cycle(); #1;
            chk($sformatf("race_wait_ready_%0d", i), 32'(m1_ready), 32'd0);
        end
        next_cycle();
        s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
        #1;
        chk("race_m1_ready", 32'(m1_ready), 32'd1);
        chk("race_m1_rdata", m1_rdata, 32'hCAFE_F00D);
        chk("race_terr", 32'(timeout_err), 32'd0);
        next_cycle();
        m1_valid = 1'b0; s_ready = 1'b0;
        #1;
        chk("race_idle_grant", 32'(grant), 32'd0);

        // Reset asserted during GRANT0.
        m0_valid = 1'b1;
        next_cycle(); #1;
        chk("rmid_grant", 32'(grant), 32'd1);
        reset_n = 1'b0;
        next_cycle(); #1;
        chk("rmid_s_valid", 32'(s_valid), 32'd0);
        chk("rmid_grant_idle", 32'(grant), 32'd0);
        chk("rmid_m0_ready", 32'(m0_ready), 32'd0);
        reset_n = 1'b1; m0_valid = 1'b0;

        // m0 drops valid mid-grant: silent abort, tie history untouched.
        next_cycle();
        m0_valid = 1'b1;
        next_cycle(); #1;
        chk("ab_grant", 32'(grant), 32'd1);
        m0_valid = 1'b0; s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
        #1;
        chk("ab_m0_ready", 32'(m0_ready), 32'd0);
        chk("ab_terr", 32'(timeout_err), 32'd0);
        next_cycle();
        s_ready = 1'b0;
        #1;
        chk("ab_s_valid", 32'(s_valid), 32'd0);
        chk("ab_grant_idle", 32'(grant), 32'd0);
        m0_valid = 1'b1; m1_valid = 1'b1;
        next_cycle(); #1;
        chk("ab_tie_to_m0", 32'(grant), 32'd1);
        m0_valid = 1'b0; m1_valid = 1'b0;
        next_cycle(); next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_bus_arbiter
